// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive and transmit paths.
//   - uart_state_e : receiver FSM state encoding
//   - par_typ_e    : parity type encoding (EVEN = 0, ODD = 1)
//   - PRESCALE_*   : the only legal oversampling ratios
//   - is_legal_prescale(), maj3() : small helpers used by the receiver
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_typ_e;

  localparam logic [5:0] PRESCALE_8  = 6'd8;
  localparam logic [5:0] PRESCALE_16 = 6'd16;
  localparam logic [5:0] PRESCALE_32 = 6'd32;

  function automatic logic is_legal_prescale(input logic [5:0] p);
    return (p == PRESCALE_8) || (p == PRESCALE_16) || (p == PRESCALE_32);
  endfunction

  // 2-of-3 majority of the three mid-bit samples
  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: per-bit timing and majority sampling for the UART receiver.
// Ports:
//   CLK, RST     : oversampling clock, async active-low reset
//   rx_s         : synchronized serial input
//   prescale     : oversampling ratio P captured for the current frame
//   enable       : high while a frame is being received; low holds edge_cnt at 0
//   bit_done     : high in the last oversampling cycle of a bit (edge_cnt = P-1)
//   sample_valid : high once all three samples of the current bit are taken
//   bit_val      : majority of the samples at edge_cnt = P/2-1, P/2, P/2+1
module uart_rx_sampler
  import uart_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       rx_s,
  input  logic [5:0] prescale,
  input  logic       enable,
  output logic       bit_done,
  output logic       sample_valid,
  output logic       bit_val
);

  logic [5:0] edge_cnt_q, edge_cnt_d;
  logic [2:0] smp_q, smp_d;
  logic [5:0] half_s;

  assign half_s = {1'b0, prescale[5:1]};

  // Next edge count (wraps every P cycles) and capture of the three mid-bit samples
  always_comb begin
    edge_cnt_d = edge_cnt_q;
    smp_d      = smp_q;
    if (!enable) begin
      edge_cnt_d = 6'd0;
    end else if (edge_cnt_q == prescale - 6'd1) begin
      edge_cnt_d = 6'd0;
    end else begin
      edge_cnt_d = edge_cnt_q + 6'd1;
    end
    if (enable && (edge_cnt_q == half_s - 6'd1)) begin
      smp_d[0] = rx_s;
    end else if (enable && (edge_cnt_q == half_s)) begin
      smp_d[1] = rx_s;
    end else if (enable && (edge_cnt_q == half_s + 6'd1)) begin
      smp_d[2] = rx_s;
    end else begin
      smp_d = smp_q;
    end
  end

  // Counter and sample registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt_q <= 6'd0;
      smp_q      <= 3'b111;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      smp_q      <= smp_d;
    end
  end

  assign bit_done     = enable && (edge_cnt_q == prescale - 6'd1);
  // All three samples are registered once edge_cnt reaches P/2+2
  assign sample_valid = enable && (edge_cnt_q >= half_s + 6'd2);
  assign bit_val      = maj3(smp_q);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver. Oversamples RX_IN at Prescale x baud, checks optional
// parity and the stop bit, and presents the byte with one-cycle strobes.
// Ports:
//   CLK, RST   : oversampling clock, async active-low reset
//   RX_IN      : serial line (asynchronous, idle high)
//   PAR_EN     : frame carries a parity bit
//   PAR_TYP    : 0 = even parity, 1 = odd parity
//   Prescale   : oversampling ratio, 8/16/32 legal
//   P_DATA     : last good payload, updated only with data_valid
//   data_valid : one-cycle strobe, good frame received
//   par_err    : one-cycle strobe, parity mismatch
//   stp_err    : one-cycle strobe, stop bit sampled as 0
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
)
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BCW = $clog2(DATA_WIDTH);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shadow_q, shadow_d;
  logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
  logic [5:0]            prescale_q, prescale_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  par_bad_q, par_bad_d;
  logic                  data_valid_q, data_valid_d;
  logic                  par_err_q, par_err_d;
  logic                  stp_err_q, stp_err_d;

  logic rx_s;
  logic enable_s;
  logic bit_done_s;
  logic sample_valid_s;
  logic bit_val_s;

  function automatic logic expected_parity(input logic [DATA_WIDTH-1:0] data,
                                           input logic par_typ);
    return (^data) ^ (par_typ == PAR_ODD);
  endfunction

  assign rx_s     = sync_q[1];
  assign enable_s = (state_q != ST_IDLE);

  uart_rx_sampler u_sampler (
    .CLK          (CLK),
    .RST          (RST),
    .rx_s         (rx_s),
    .prescale     (prescale_q),
    .enable       (enable_s),
    .bit_done     (bit_done_s),
    .sample_valid (sample_valid_s),
    .bit_val      (bit_val_s)
  );

  // Next-state logic: frame FSM, deserializer, parity/stop checks and strobes
  always_comb begin
    sync_d       = {sync_q[0], RX_IN};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shadow_d     = shadow_q;
    p_data_d     = p_data_q;
    prescale_d   = prescale_q;
    par_en_d     = par_en_q;
    par_typ_d    = par_typ_q;
    par_bad_d    = par_bad_q;
    data_valid_d = 1'b0;
    par_err_d    = 1'b0;
    stp_err_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Config is frozen here so mid-frame input changes are ignored
        if (!rx_s && is_legal_prescale(Prescale)) begin
          state_d    = ST_START;
          prescale_d = Prescale;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          bit_cnt_d  = {BCW{1'b0}};
          shadow_d   = {DATA_WIDTH{1'b0}};
          par_bad_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        // A start bit that votes high was a glitch: abandon without strobes
        if (sample_valid_s && bit_val_s) begin
          state_d = ST_IDLE;
        end else if (bit_done_s) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_done_s) begin
          shadow_d[bit_cnt_q] = bit_val_s;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = {BCW{1'b0}};
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + {{(BCW-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_done_s) begin
          par_bad_d = (bit_val_s != expected_parity(shadow_q, par_typ_q));
          state_d   = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_done_s) begin
          if (bit_val_s && !par_bad_q) begin
            p_data_d     = shadow_q;
            data_valid_d = 1'b1;
          end else begin
            p_data_d = p_data_q;
          end
          par_err_d = par_bad_q;
          stp_err_d = !bit_val_s;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All receiver state and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      sync_q       <= 2'b11;
      bit_cnt_q    <= {BCW{1'b0}};
      shadow_q     <= {DATA_WIDTH{1'b0}};
      p_data_q     <= {DATA_WIDTH{1'b0}};
      prescale_q   <= PRESCALE_8;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_bad_q    <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      bit_cnt_q    <= bit_cnt_d;
      shadow_q     <= shadow_d;
      p_data_q     <= p_data_d;
      prescale_q   <= prescale_d;
      par_en_q     <= par_en_d;
      par_typ_q    <= par_typ_d;
      par_bad_q    <= par_bad_d;
      data_valid_q <= data_valid_d;
      par_err_q    <= par_err_d;
      stp_err_q    <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign data_valid = data_valid_q;
  assign par_err    = par_err_q;
  assign stp_err    = stp_err_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Receive half of the UART interface: recovers frames from the serial line `RX_IN` by oversampling at `Prescale`× the bit rate, checks optional parity and the stop bit, and presents the parallel byte with a one-cycle `data_valid` strobe. It mirrors the transmit path: start bit (0), `DATA_WIDTH` data bits LSB first, optional parity bit, one stop bit (1), idle line high. It sits between the pad-side serial input and the system-side consumer, such as a FIFO or register file. There is no back-pressure.

## Interface
- `DATA_WIDTH`, 8: payload bits per frame.
- `CLK` input 1: oversampling clock, Prescale × baud.
- `RST` input 1: reset, asynchronous, active-low.
- `RX_IN` input 1: serial line, asynchronous to `CLK`, idle high.
- `PAR_EN` input 1: 1 = frame carries a parity bit.
- `PAR_TYP` input 1: 0 = even parity, 1 = odd parity.
- `Prescale` input 6: oversampling ratio; only 8, 16 or 32 are legal.
- `P_DATA` output DATA_WIDTH: last good payload.
- `data_valid` output 1: one-cycle strobe when `P_DATA` is updated.
- `par_err` output 1: one-cycle strobe, parity mismatch.
- `stp_err` output 1: one-cycle strobe, stop bit sampled as 0.

## Operation
- **Synchronizer:** `RX_IN` passes through a 2-flop synchronizer. All logic uses the synchronized value `rx_s`.
- **Config capture:** `PAR_EN`, `PAR_TYP` and `Prescale` are captured on the IDLE→START transition and held for the whole frame. Mid-frame changes have no effect.
- **Bit timing:** `edge_cnt` counts 0..P-1 within each bit, and `bit_cnt` counts data bits 0..DATA_WIDTH-1.
- **Sampling:** each bit is sampled at `edge_cnt` = P/2-1, P/2 and P/2+1. The bit value is the 2-of-3 majority, valid from `edge_cnt` = P/2+2.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** when `rx_s` = 0 and `Prescale` is legal, go to START with `edge_cnt` = 0. With an illegal `Prescale`, stay in IDLE.
  - **START:** if the majority value is 1 (glitch), return to IDLE immediately with no strobes. Otherwise, at `edge_cnt` = P-1 go to DATA.
  - **DATA:** the majority bit is shifted into `P_DATA[bit_cnt]` (LSB first) in a shadow register. After bit DATA_WIDTH-1, at `edge_cnt` = P-1, go to PARITY if `PAR_EN`, else STOP.
  - **PARITY:** the expected bit is XOR of the shadow register XOR `PAR_TYP`. A mismatch sets an internal error flag. At `edge_cnt` = P-1 go to STOP.
  - **STOP:** at `edge_cnt` = P-1:
    - If the stop bit = 1 and there is no parity error: copy shadow to `P_DATA` and pulse `data_valid`.
    - If parity failed: pulse `par_err`.
    - If the stop bit = 0: pulse `stp_err`. Both `par_err` and `stp_err` may pulse together.
    - Go to IDLE.
- `P_DATA` changes only on `data_valid` and holds its value otherwise.
- Errored frames never assert `data_valid`.
- **Reset:** `RST` low at any time (including mid-frame) forces IDLE, zeroes all counters and the shadow register, and sets `P_DATA` = 0, `data_valid`/`par_err`/`stp_err` = 0, synchronizer flops = 1. The current frame is discarded.

## Timing
- All outputs are registered.
- Latency: with F = frame bits (1 + DATA_WIDTH + PAR_EN + 1) and edge 0 = first `CLK` edge that samples `RX_IN` low, the strobes are high in the cycle after edge 3 + P·F − 1.
  - Example, P=8, F=10: edge 82.
- Each strobe lasts exactly 1 cycle.
- Back-to-back frames: STOP→IDLE happens at the end of the stop bit. A start edge arriving immediately is detected in IDLE on the next cycle, giving ≤1-cycle phase slip, which is absorbed by mid-bit sampling.
- Tolerated baud mismatch: ±3 % at P=8.
- A start glitch shorter than P/2−1 cycles returns to IDLE by `edge_cnt` = P/2+2 of START.

## Structure
- **Package `uart_pkg`:** FSM state encoding, legal prescale constants (8/16/32), and the parity-type encoding (EVEN=0, ODD=1), shared with the transmit path.
- **Sub-module `uart_rx_sampler`:**
  - Contents: `edge_cnt` counter, 3-point majority vote, bit-done and sample-valid flags.
  - Inputs: `rx_s`, prescale, enable.
- **Top level:** `uart_rx` holds the synchronizer, FSM, `bit_cnt`, deserializer, parity check and output registers.

## Test plan
- **Clean frame:** P=8, `PAR_EN`=0, send 0xA5 → `data_valid` for 1 cycle at edge 82, `P_DATA`=0xA5, no errors.
- **Parity good/bad:** P=16, `PAR_EN`=1, `PAR_TYP`=0, send 0x3C with parity 0 → valid, `P_DATA`=0x3C. Resend with parity 1 → `par_err` only, `P_DATA` stays 0x3C.
- **Stop error:** P=32, send 0x0F with stop = 0 → `stp_err` pulse, no `data_valid`, FSM back in IDLE, next frame 0xF0 received correctly.
- **Glitch and majority:**
  - A 2-cycle low pulse on an idle line at P=8 → no strobes, FSM back in IDLE.
  - A data bit with a single-cycle inverted sample at P/2 → correct bit recovered.
- **Back-to-back and drift:** 4 frames 0x00, 0xFF, 0x55, 0xAA with no idle gap and the TX bit period stretched +3 % → 4 `data_valid` strobes with correct data.
- **Reset mid-frame:** assert `RST` during DATA bit 4 → all outputs 0 immediately, no strobe. After release, 0x81 is received correctly.
